// File: rtl/rle_plane_scheduler.sv
// Shares one CLUT7 RLE decoder between video planes A and B, one line at a time.
// Optional stall watchdog with zero padding: define RLE_SCHED_WATCHDOG_EN.
module rle_plane_scheduler #(
    parameter int LINE_PIXELS     = 384,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       line_start,
    input  logic [1:0] plane_en,
    input  logic [1:0] plane_rle,
    input  logic [7:0] src_a_pixel,
    input  logic       src_a_write,
    output logic       src_a_strobe,
    input  logic [7:0] src_b_pixel,
    input  logic       src_b_write,
    output logic       src_b_strobe,
    output logic [7:0] dec_src_pixel,
    output logic       dec_src_write,
    input  logic       dec_src_strobe,
    input  logic [7:0] dec_dst_pixel,
    input  logic       dec_dst_write,
    output logic       dec_dst_strobe,
    output logic       dec_passthrough,
    output logic       dec_reset,
    output logic [7:0] out_a_pixel,
    output logic       out_a_write,
    input  logic       out_a_strobe,
    output logic [7:0] out_b_pixel,
    output logic       out_b_write,
    input  logic       out_b_strobe,
    output logic       busy,
    output logic       line_done,
    output logic       overrun,
    output logic       stall_err,
    output logic [2:0] state_dbg
);

    if (LINE_PIXELS < 1 || LINE_PIXELS > 2047 || WATCHDOG_CYCLES < 1) begin : g_bad_param
        $error("rle_plane_scheduler: parameter out of range");
    end

    // Every stream below is valid/ready: a beat moves on a clock edge where
    // write and strobe are both high; a held write keeps its pixel stable.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FLUSH_A = 3'd1,
        S_RUN_A   = 3'd2,
        S_FLUSH_B = 3'd4,
        S_RUN_B   = 3'd5,
        S_DONE    = 3'd7
`ifdef RLE_SCHED_WATCHDOG_EN
        ,
        S_PAD_A   = 3'd3,
        S_PAD_B   = 3'd6
`endif
    } state_t;

    localparam logic [10:0] LIMIT = 11'(LINE_PIXELS);
    localparam logic [10:0] LAST  = 11'(LINE_PIXELS - 1);

    state_t      state;
    logic [1:0]  en_q;
    logic [1:0]  rle_q;
    logic [10:0] cnt;
    logic        cnt_ok;
    logic        hs;

    assign cnt_ok    = cnt < LIMIT;
    assign hs        = (out_a_write & out_a_strobe) | (out_b_write & out_b_strobe);
    assign busy      = state != S_IDLE;
    assign line_done = state == S_DONE;
    assign state_dbg = state;
    assign dec_reset = ~reset_n | (state == S_FLUSH_A) | (state == S_FLUSH_B);

    always_comb begin
        src_a_strobe    = 1'b0;
        src_b_strobe    = 1'b0;
        dec_src_pixel   = 8'h00;
        dec_src_write   = 1'b0;
        dec_dst_strobe  = 1'b0;
        out_a_pixel     = 8'h00;
        out_a_write     = 1'b0;
        out_b_pixel     = 8'h00;
        out_b_write     = 1'b0;
        dec_passthrough = 1'b1;
        case (state)
            S_FLUSH_A: dec_passthrough = ~rle_q[0];
            S_RUN_A: begin
                dec_passthrough = ~rle_q[0];
                dec_src_pixel   = src_a_pixel;
                dec_src_write   = src_a_write;
                src_a_strobe    = dec_src_strobe;
                out_a_pixel     = dec_dst_pixel;
                out_a_write     = dec_dst_write & cnt_ok;
                dec_dst_strobe  = out_a_strobe;
            end
            S_FLUSH_B: dec_passthrough = ~rle_q[1];
            S_RUN_B: begin
                dec_passthrough = ~rle_q[1];
                dec_src_pixel   = src_b_pixel;
                dec_src_write   = src_b_write;
                src_b_strobe    = dec_src_strobe;
                out_b_pixel     = dec_dst_pixel;
                out_b_write     = dec_dst_write & cnt_ok;
                dec_dst_strobe  = out_b_strobe;
            end
`ifdef RLE_SCHED_WATCHDOG_EN
            // Padding pixels are zero; the decoder is left frozen until the next flush.
            S_PAD_A: begin
                dec_passthrough = ~rle_q[0];
                out_a_write     = cnt_ok;
            end
            S_PAD_B: begin
                dec_passthrough = ~rle_q[1];
                out_b_write     = cnt_ok;
            end
`endif
            default: ;
        endcase
    end

`ifdef RLE_SCHED_WATCHDOG_EN
    localparam int              WD_W    = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt;
`else
    assign stall_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            en_q    <= 2'b00;
            rle_q   <= 2'b00;
            cnt     <= 11'd0;
            overrun <= 1'b0;
`ifdef RLE_SCHED_WATCHDOG_EN
            wd_cnt    <= '0;
            stall_err <= 1'b0;
`endif
        end else begin
            if (line_start && state != S_IDLE)
                overrun <= 1'b1;
            if (hs)
                cnt <= cnt + 11'd1;
            case (state)
                S_IDLE: begin
                    if (line_start) begin
                        en_q  <= plane_en;
                        rle_q <= plane_rle;
                        state <= S_FLUSH_A;
                    end
                end
                S_FLUSH_A: begin
                    cnt   <= 11'd0;
                    state <= en_q[0] ? S_RUN_A : S_FLUSH_B;
`ifdef RLE_SCHED_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                end
                S_RUN_A: begin
                    if (hs && cnt == LAST)
                        state <= S_FLUSH_B;
`ifdef RLE_SCHED_WATCHDOG_EN
                    else if (!hs && wd_cnt == WD_LAST) begin
                        state     <= S_PAD_A;
                        stall_err <= 1'b1;
                    end
                    wd_cnt <= hs ? '0 : wd_cnt + 1'b1;
`endif
                end
                S_FLUSH_B: begin
                    cnt   <= 11'd0;
                    state <= en_q[1] ? S_RUN_B : S_DONE;
`ifdef RLE_SCHED_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                end
                S_RUN_B: begin
                    if (hs && cnt == LAST)
                        state <= S_DONE;
`ifdef RLE_SCHED_WATCHDOG_EN
                    else if (!hs && wd_cnt == WD_LAST) begin
                        state     <= S_PAD_B;
                        stall_err <= 1'b1;
                    end
                    wd_cnt <= hs ? '0 : wd_cnt + 1'b1;
`endif
                end
`ifdef RLE_SCHED_WATCHDOG_EN
                S_PAD_A: if (hs && cnt == LAST) state <= S_FLUSH_B;
                S_PAD_B: if (hs && cnt == LAST) state <= S_DONE;
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rle_plane_scheduler.sv
// Randomized bench for rle_plane_scheduler: a behavioural CLUT7 decoder, DMA
// sources and pixel sinks, scored against a per-line expansion of each stream.
module tb_rle_plane_scheduler;

    localparam int LP = 384;
    localparam int WD = 32;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset_n;
    logic       line_start;
    logic [1:0] plane_en, plane_rle;
    logic [7:0] src_a_pixel = 8'h00, src_b_pixel = 8'h00;
    logic       src_a_write = 1'b0, src_b_write = 1'b0;
    logic       src_a_strobe, src_b_strobe;
    logic [7:0] dec_src_pixel;
    logic       dec_src_write, dec_src_strobe;
    logic [7:0] dec_dst_pixel;
    logic       dec_dst_write, dec_dst_strobe;
    logic       dec_passthrough, dec_reset;
    logic [7:0] out_a_pixel, out_b_pixel;
    logic       out_a_write, out_b_write;
    logic       out_a_strobe = 1'b0, out_b_strobe = 1'b0;
    logic       busy, line_done, overrun, stall_err;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    rle_plane_scheduler #(.LINE_PIXELS(LP), .WATCHDOG_CYCLES(WD)) dut (
        .clk(clk), .reset_n(reset_n), .line_start(line_start),
        .plane_en(plane_en), .plane_rle(plane_rle),
        .src_a_pixel(src_a_pixel), .src_a_write(src_a_write), .src_a_strobe(src_a_strobe),
        .src_b_pixel(src_b_pixel), .src_b_write(src_b_write), .src_b_strobe(src_b_strobe),
        .dec_src_pixel(dec_src_pixel), .dec_src_write(dec_src_write), .dec_src_strobe(dec_src_strobe),
        .dec_dst_pixel(dec_dst_pixel), .dec_dst_write(dec_dst_write), .dec_dst_strobe(dec_dst_strobe),
        .dec_passthrough(dec_passthrough), .dec_reset(dec_reset),
        .out_a_pixel(out_a_pixel), .out_a_write(out_a_write), .out_a_strobe(out_a_strobe),
        .out_b_pixel(out_b_pixel), .out_b_write(out_b_write), .out_b_strobe(out_b_strobe),
        .busy(busy), .line_done(line_done), .overrun(overrun), .stall_err(stall_err),
        .state_dbg(state_dbg)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Decoder: bit7 byte = run header (value = low 7 bits), next byte = run
    // length with 0 meaning endless; other bytes are literals. Passthrough copies.
    logic       dm_pend_v = 1'b0;
    logic [7:0] dm_pend_p = 8'h00;
    int         dm_run = 0;
    logic [6:0] dm_run_pix = 7'h00;
    logic       dm_hdr = 1'b0;

    assign dec_dst_write  = dm_pend_v;
    assign dec_dst_pixel  = dm_pend_p;
    assign dec_src_strobe = (dm_run == 0) && (!dm_pend_v || dec_dst_strobe);

    always @(posedge clk) begin
        if (dec_reset) begin
            dm_pend_v <= 1'b0;
            dm_run    <= 0;
            dm_hdr    <= 1'b0;
        end else if (!dm_pend_v || dec_dst_strobe) begin
            if (dm_run != 0) begin
                dm_pend_v <= 1'b1;
                dm_pend_p <= {1'b0, dm_run_pix};
                if (dm_run > 0) dm_run <= dm_run - 1;
            end else if (dec_src_write) begin
                if (dec_passthrough || (!dm_hdr && !dec_src_pixel[7])) begin
                    dm_pend_v <= 1'b1;
                    dm_pend_p <= dec_src_pixel;
                end else if (dm_hdr) begin
                    dm_pend_v <= 1'b0;
                    dm_hdr    <= 1'b0;
                    dm_run    <= (dec_src_pixel == 8'h00) ? -1 : int'(dec_src_pixel);
                end else begin
                    dm_pend_v  <= 1'b0;
                    dm_hdr     <= 1'b1;
                    dm_run_pix <= dec_src_pixel[6:0];
                end
            end else begin
                dm_pend_v <= 1'b0;
            end
        end
    end

    // Sources, sinks, scoreboard state
    logic [7:0] src_q_a[$], src_q_b[$];
    logic [7:0] exp_q_a[$], exp_q_b[$];
    bit   hold_a = 1'b0;
    bit   src_hs_a, src_hs_b;
    int   pops_a, pops_b;
    int   cyc = 0, dres_cnt, done_cnt, done_cyc, last_hs_cyc, start_cyc;
    bit   pad_a = 1'b0, stall_seen = 1'b0, prev_wait = 1'b0;
    logic [7:0] prev_pix, e;

    always @(posedge clk) begin
        #1;
        if (src_hs_a && src_q_a.size() > 0) begin void'(src_q_a.pop_front()); pops_a++; end
        if (src_hs_b && src_q_b.size() > 0) begin void'(src_q_b.pop_front()); pops_b++; end
        src_a_write = (src_q_a.size() > 0) && ((src_a_write && !src_hs_a) || $urandom_range(0, 4) != 0);
        src_b_write = (src_q_b.size() > 0) && ((src_b_write && !src_hs_b) || $urandom_range(0, 4) != 0);
        src_a_pixel = (src_q_a.size() > 0) ? src_q_a[0] : 8'h00;
        src_b_pixel = (src_q_b.size() > 0) ? src_q_b[0] : 8'h00;
        out_a_strobe = hold_a ? 1'b0 : ($urandom_range(0, 3) != 0);
        out_b_strobe = $urandom_range(0, 3) != 0;
    end

    always @(negedge clk) begin
        cyc++;
        src_hs_a = src_a_write && src_a_strobe;
        src_hs_b = src_b_write && src_b_strobe;
        if (reset_n) begin
            if (dec_reset) dres_cnt++;
            if (line_done) begin done_cnt++; done_cyc = cyc; end
            if (line_start && !busy) start_cyc = cyc;
`ifdef RLE_SCHED_WATCHDOG_EN
            if (stall_err && !stall_seen) begin stall_seen = 1'b1; pad_a = 1'b1; end
`else
            if (prev_wait) check("a_hold", {out_a_write, out_a_pixel}, {1'b1, prev_pix});
`endif
            if (out_a_write && out_a_strobe) begin
                last_hs_cyc = cyc;
                if (exp_q_a.size() == 0) check("a_extra", 1, 0);
                else begin
                    e = exp_q_a.pop_front();
                    check("a_pix", out_a_pixel, pad_a ? 8'h00 : e);
                end
            end
            if (out_b_write && out_b_strobe) begin
                last_hs_cyc = cyc;
                if (exp_q_b.size() == 0) check("b_extra", 1, 0);
                else begin
                    e = exp_q_b.pop_front();
                    check("b_pix", out_b_pixel, e);
                end
            end
            prev_wait = out_a_write && !out_a_strobe;
            prev_pix  = out_a_pixel;
        end else begin
            prev_wait  = 1'b0;
            stall_seen = 1'b0;
        end
    end

    // Reference: expand a plane's byte stream into the first LP pixels
    task automatic expand(input int plane, input bit rle);
        bq_t src = (plane == 0) ? src_q_a : src_q_b;
        bq_t pix = {};
        int  i = 0;
        int  reps;
        logic [7:0] b;
        while (pix.size() < LP && i < src.size()) begin
            b = src[i];
            i++;
            if (!rle || !b[7]) pix.push_back(b);
            else if (i < src.size()) begin
                reps = (src[i] == 8'h00) ? LP : int'(src[i]);
                i++;
                for (int k = 0; k < reps && pix.size() < LP; k++) pix.push_back({1'b0, b[6:0]});
            end
        end
        if (plane == 0) exp_q_a = pix;
        else exp_q_b = pix;
    endtask

    task automatic gen_stream(input int plane, input bit rle);
        bq_t s = {};
        int  px = 0;
        int  n;
        while (px < LP + 8) begin
            if (!rle) begin
                s.push_back(8'($urandom));
                px++;
            end else if ($urandom_range(0, 2) == 0) begin
                n = $urandom_range(1, 40);
                s.push_back(8'h80 | 8'($urandom_range(0, 127)));
                s.push_back(8'(n));
                px += n;
            end else begin
                s.push_back(8'($urandom_range(0, 127)));
                px++;
            end
        end
        if (plane == 0) src_q_a = s;
        else src_q_b = s;
    endtask

    bit stall_exp = 1'b0;

    task automatic run_line(input logic [1:0] en, input logic [1:0] rle, input bit stall,
                            input bit dbl, input bit exp_ovr);
        int n;
        exp_q_a.delete();
        exp_q_b.delete();
        if (en[0]) expand(0, rle[0]);
        if (en[1]) expand(1, rle[1]);
        dres_cnt = 0; done_cnt = 0; pops_a = 0; pops_b = 0; pad_a = 1'b0;
        @(posedge clk); #1;
        line_start = 1'b1; plane_en = en; plane_rle = rle;
        @(posedge clk); #1;
        line_start = 1'b0; plane_en = 2'($urandom); plane_rle = 2'($urandom);
        if (stall) begin
            n = 0;
            while (exp_q_a.size() > LP - 200 && n < 4000) begin @(posedge clk); n++; end
            #1 hold_a = 1'b1;
            repeat (50) @(posedge clk);
            #1 hold_a = 1'b0;
        end
        if (dbl) begin
            n = 0;
            while (exp_q_b.size() > LP / 2 && n < 6000) begin @(posedge clk); n++; end
            #1 line_start = 1'b1;
            @(posedge clk); #1 line_start = 1'b0;
        end
        n = 0;
        while (done_cnt == 0 && n < 8000) begin @(negedge clk); n++; end
        check("done_timeout", done_cnt > 0, 1);
        repeat (6) @(negedge clk);
        check("done_once", done_cnt, 1);
        check("dec_reset_pulses", dres_cnt, 2);
        check("a_left", exp_q_a.size(), 0);
        check("b_left", exp_q_b.size(), 0);
        check("busy_end", busy, 0);
        check("overrun", overrun, exp_ovr);
        check("stall_err", stall_err, stall_exp);
        if (en != 2'b00) check("done_latency", done_cyc - last_hs_cyc, en[1] ? 1 : 2);
        else check("done_latency_idle", done_cyc - start_cyc, 3);
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        bq_t s;
        int  n;
        reset_n = 1'b0; line_start = 1'b0; plane_en = 2'b00; plane_rle = 2'b00;
        repeat (3) @(posedge clk);
        #1 check("rst_dec_reset", dec_reset, 1);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_line_done", line_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_stall_err", stall_err, 0);
        check("rst_dec_reset_off", dec_reset, 0);
        check("rst_passthrough", dec_passthrough, 1);
        check("rst_out_write", {out_a_write, out_b_write, src_a_strobe, src_b_strobe}, 0);

        // Both planes passthrough, counting bytes
        s = {};
        for (int i = 0; i < LP + 4; i++) s.push_back(8'(i + 1));
        src_q_a = s; src_q_b = s;
        run_line(2'b11, 2'b00, 0, 0, 0);

        // Endless run of 5 on plane A only
        src_q_a = {8'h85, 8'h00, 8'h11, 8'h22, 8'h33};
        run_line(2'b01, 2'b01, 0, 0, 0);
        check("a_src_pops", pops_a, 2);
        check("a_src_left", src_q_a.size(), 3);

        // Counted run followed by literals
        s = {8'h83, 8'h0A};
        for (int i = 0; i < 400; i++) s.push_back(8'h10);
        src_q_a = s;
        run_line(2'b01, 2'b01, 0, 0, 0);

        for (int l = 0; l < 4; l++) begin
            logic [1:0] en, rle;
            en  = 2'($urandom_range(1, 3));
            rle = 2'($urandom);
            gen_stream(0, rle[0]);
            gen_stream(1, rle[1]);
            run_line(en, rle, 0, 0, 0);
        end

        run_line(2'b00, 2'b00, 0, 0, 0);

        // Sink stall on plane A
        gen_stream(0, 1'b0);
`ifdef RLE_SCHED_WATCHDOG_EN
        stall_exp = 1'b1;
`endif
        run_line(2'b01, 2'b00, 1, 0, 0);

        // Second line_start while plane B is running
        gen_stream(0, 1'b1);
        gen_stream(1, 1'b0);
        run_line(2'b11, 2'b01, 0, 1, 1);

        // Reset after exactly 100 plane-A pixels
        gen_stream(0, 1'b0);
        expand(0, 1'b0);
        exp_q_b.delete();
        @(posedge clk); #1 line_start = 1'b1; plane_en = 2'b01; plane_rle = 2'b00;
        @(posedge clk); #1 line_start = 1'b0;
        n = 0;
        while (exp_q_a.size() > LP - 100 && n < 4000) begin @(posedge clk); n++; end
        check("reset_point", LP - exp_q_a.size(), 100);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("midline_dec_reset", dec_reset, 1);
        @(posedge clk); #1 reset_n = 1'b1;
        src_q_a.delete(); src_q_b.delete();
        stall_exp = 1'b0;
        @(negedge clk);
        check("midline_busy", busy, 0);
        check("midline_overrun", overrun, 0);
        check("midline_stall_err", stall_err, 0);
        repeat (2) @(posedge clk);
        gen_stream(0, 1'b1);
        gen_stream(1, 1'b1);
        run_line(2'b11, 2'b11, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
